// File: rtl/multicycle_core_ctrl_if.sv
// Instruction-memory request/acknowledge port between the sequencer and imem.
interface multicycle_core_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/multicycle_core_ctrl.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/WB with TRAP on unsupported encodings.
// Optional perf counters under `define MULTICYCLE_CORE_CTRL_PERF_EN.
module multicycle_core_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  multicycle_core_ctrl_if.master imem,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [3:0]  alu_op,
  output logic        bsel,
  output logic        reg_wen,
  output logic        busy,
  output logic        illegal,
  output logic        retired
`ifdef MULTICYCLE_CORE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, TRAP} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_instr;
  logic [3:0]  r_alu_op, w_dec_op;
  logic        r_bsel, w_dec_bsel, w_dec_ok;
  logic        r_illegal;
  logic        w_req, w_busy, w_retired, w_wen;

  always_comb begin
    w_dec_op   = OP_ADD;
    w_dec_bsel = 1'b0;
    w_dec_ok   = 1'b0;
    case (r_instr[6:0])
      7'b0110011: begin
        w_dec_ok = 1'b1;
        case ({r_instr[31:25], r_instr[14:12]})
          10'b0000000_000: w_dec_op = OP_ADD;
          10'b0100000_000: w_dec_op = OP_SUB;
          10'b0000000_110: w_dec_op = OP_OR;
          10'b0000000_111: w_dec_op = OP_AND;
          default:         w_dec_ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        w_dec_ok   = 1'b1;
        w_dec_bsel = 1'b1;
        case (r_instr[14:12])
          3'b000:  w_dec_op = OP_ADD;
          3'b110:  w_dec_op = OP_OR;
          3'b111:  w_dec_op = OP_AND;
          default: w_dec_ok = 1'b0;
        endcase
      end
      default: w_dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_req     = 1'b0;
    w_busy    = 1'b1;
    w_retired = 1'b0;
    w_wen     = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = FETCH;
      end
      FETCH: begin
        w_req = 1'b1;
        if (imem.imem_ack) w_next = DECODE;
      end
      DECODE: w_next = w_dec_ok ? EXEC : TRAP;
      EXEC:   w_next = WB;
      WB: begin
        w_retired = 1'b1;
        w_wen     = (r_instr[11:7] != 5'd0);
        w_next    = stop ? IDLE : FETCH;
      end
      TRAP:    w_busy = 1'b0;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_alu_op  <= OP_ADD;
      r_bsel    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && imem.imem_ack) r_instr <= imem.imem_rdata;
      // alu_op/bsel only move in DECODE so they are stable through EXEC and WB
      if (r_state == DECODE) begin
        if (w_dec_ok) begin
          r_alu_op <= w_dec_op;
          r_bsel   <= w_dec_bsel;
        end else begin
          r_illegal <= 1'b1;
        end
      end
      if (r_state == WB) r_pc <= r_pc + 32'(PC_STEP);
    end
  end

`ifdef MULTICYCLE_CORE_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt, r_instret_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (w_busy)    r_cycle_cnt   <= r_cycle_cnt + 32'd1;
      if (w_retired) r_instret_cnt <= r_instret_cnt + 32'd1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;
  assign pc             = r_pc;
  assign instr          = r_instr;
  assign alu_op         = r_alu_op;
  assign bsel           = r_bsel;
  assign reg_wen        = w_wen;
  assign busy           = w_busy;
  assign illegal        = r_illegal;
  assign retired        = w_retired;

endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Directed bench for multicycle_core_ctrl with an expected-result queue per fetched instruction.
module tb_multicycle_core_ctrl;
  logic        clk, rst_n, start, stop;
  logic [31:0] pc, instr;
  logic [3:0]  alu_op;
  logic        bsel, reg_wen, busy, illegal, retired;
`ifdef MULTICYCLE_CORE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_core_ctrl_if bus ();

  multicycle_core_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .imem(bus.master),
    .pc(pc), .instr(instr), .alu_op(alu_op), .bsel(bsel), .reg_wen(reg_wen),
    .busy(busy), .illegal(illegal), .retired(retired)
`ifdef MULTICYCLE_CORE_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  typedef struct {
    logic [3:0]  op;
    logic        bsel;
    logic        wen;
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Serve one fetch (ack after 'waits' stalled cycles) and check it through WB.
  task automatic do_instr(input logic [31:0] data, input int waits,
                          input logic [3:0] op, input logic b, input logic wen);
    int          n;
    logic [31:0] a0;
    exp_t        e, g;
    n = 0;
    while (!bus.imem_req && n < 20) begin step; n++; end
    chk("req_seen", {31'd0, bus.imem_req}, 32'd1);
    a0 = bus.imem_addr;
    chk("addr_eq_pc", a0, pc);
    e = '{op: op, bsel: b, wen: wen, pc: a0, ins: data};
    sb.push_back(e);
    for (int w = 0; w < waits; w++) begin
      chk("addr_stable", bus.imem_addr, a0);
      chk("req_held", {31'd0, bus.imem_req}, 32'd1);
      step;
    end
    chk("addr_stable_ack", bus.imem_addr, a0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    step;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    chk("req_drop", {31'd0, bus.imem_req}, 32'd0);
    n = waits + 1;
    while (!retired && n < waits + 12) begin step; n++; end
    chk("latency", n + 1, waits + 4);
    g = e;
    if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      g = sb.pop_front();
      chk("alu_op", {28'd0, alu_op}, {28'd0, g.op});
      chk("bsel", {31'd0, bsel}, {31'd0, g.bsel});
      chk("reg_wen", {31'd0, reg_wen}, {31'd0, g.wen});
      chk("wb_pc", pc, g.pc);
      chk("instr", instr, g.ins);
      chk("busy_wb", {31'd0, busy}, 32'd1);
    end
    step;
    chk("pc_next", pc, g.pc + 32'd4);
    chk("retired_pulse", {31'd0, retired}, 32'd0);
    chk("wen_pulse", {31'd0, reg_wen}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; stop = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    step; step;
    chk("rst_pc", pc, 32'd0);
    chk("rst_wen", {31'd0, reg_wen}, 32'd0);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_aluop", {28'd0, alu_op}, 32'd2);
    chk("rst_retired", {31'd0, retired}, 32'd0);
    rst_n = 1'b1;
    step;
    chk("first_fetch_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_fetch_addr", bus.imem_addr, 32'd0);

    do_instr(32'h002081B3, 0, 4'b0010, 1'b0, 1'b1);  // add  x3,x1,x2   @0
    do_instr(32'h00508093, 3, 4'b0010, 1'b1, 1'b1);  // addi x1,x1,5    @4
    do_instr(32'h40208033, 0, 4'b0110, 1'b0, 1'b0);  // sub  x0,x1,x2   @8
    do_instr(32'h0020E333, 1, 4'b0001, 1'b0, 1'b1);  // or   x6,x1,x2   @12
    do_instr(32'h0020F033, 0, 4'b0000, 1'b0, 1'b0);  // and  x0,x1,x2   @16
    do_instr(32'h0070F293, 2, 4'b0000, 1'b1, 1'b1);  // andi x5,x1,7    @20

    // reset while FETCH at 24, with a stray ack during and after reset
    chk("midfetch_req", {31'd0, bus.imem_req}, 32'd1);
    rst_n = 1'b0; start = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 32'h002081B3;
    step;
    rst_n = 1'b1;
    step;
    chk("midrst_pc", pc, 32'd0);
    chk("midrst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_instr", instr, 32'd0);
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;

    start = 1'b1;
    step;
    do_instr(32'h002081B3, 0, 4'b0010, 1'b0, 1'b1);  // @0
    do_instr(32'h00508093, 0, 4'b0010, 1'b1, 1'b1);  // @4
`ifdef MULTICYCLE_CORE_CTRL_PERF_EN
    chk("instret_cnt", instret_cnt, 32'd2);
    chk("cycle_cnt", cycle_cnt, 32'd8);
`endif

    stop = 1'b1; start = 1'b0;
    do_instr(32'h0020E333, 0, 4'b0001, 1'b0, 1'b1);  // @8, stop sampled in WB
    chk("stop_pc", pc, 32'd12);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    step; step;
    chk("stop_idle_req", {31'd0, bus.imem_req}, 32'd0);

    start = 1'b1;  // start and stop both high in IDLE
    step;
    chk("resume_req", {31'd0, bus.imem_req}, 32'd1);
    chk("resume_addr", bus.imem_addr, 32'd12);
    do_instr(32'h0070F293, 0, 4'b0000, 1'b1, 1'b1);  // @12, stop still high
    chk("stop2_pc", pc, 32'd16);
    chk("stop2_busy", {31'd0, busy}, 32'd0);
    stop = 1'b0;

    // illegal encoding (ecall) at 16
    step;
    chk("ill_req", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00000073;
    step;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
    step;
    chk("trap_illegal", {31'd0, illegal}, 32'd1);
    chk("trap_busy", {31'd0, busy}, 32'd0);
    chk("trap_req", {31'd0, bus.imem_req}, 32'd0);
    chk("trap_pc", pc, 32'd16);
    stop = 1'b1;
    step; step; step;
    chk("trap_hold_req", {31'd0, bus.imem_req}, 32'd0);
    chk("trap_hold_pc", pc, 32'd16);
    chk("trap_hold_illegal", {31'd0, illegal}, 32'd1);
    chk("trap_hold_retired", {31'd0, retired}, 32'd0);

    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    step;
    rst_n = 1'b1;
    step;
    chk("recover_illegal", {31'd0, illegal}, 32'd0);
    chk("recover_pc", pc, 32'd0);
    chk("recover_busy", {31'd0, busy}, 32'd0);
`ifdef MULTICYCLE_CORE_CTRL_PERF_EN
    chk("recover_cycle_cnt", cycle_cnt, 32'd0);
    chk("recover_instret_cnt", instret_cnt, 32'd0);
`endif
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/multicycle_core_ctrl.md
Name: multicycle_core_ctrl

Overview:
Multi-cycle sequencer for the single-issue RV32 integer datapath. It fetches each instruction over a request/acknowledge instruction-memory port and latches it into the instruction register. It then decodes the instruction and drives the ALU op, operand-B select and register write-enable in the correct cycle. It also owns the PC and halts on unsupported encodings.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment applied to the PC after each retired instruction

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  level; in IDLE, begins fetching at the current PC
stop  in  1  level; sampled in WB; when high, returns to IDLE after the current instruction retires
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (equals pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction word
pc  out  32  current program counter
instr  out  32  latched instruction register
alu_op  out  4  ALU opcode: AND=0000, OR=0001, ADD=0010, SUB=0110
bsel  out  1  0 selects rs2 as operand B; 1 selects the immediate
reg_wen  out  1  one-cycle register-file write strobe
busy  out  1  high in every state except IDLE and TRAP
illegal  out  1  sticky; an unsupported instruction was decoded
retired  out  1  one-cycle pulse in WB

Behaviour:
- Reset (rst_n low at a clock edge, in any state, including mid-fetch): state=IDLE, pc=RESET_PC, instr=0, alu_op=0010, bsel=0, reg_wen=0, imem_req=0, busy=0, illegal=0, retired=0. An imem_ack arriving during or after reset while in IDLE is ignored.
- States: IDLE, FETCH, DECODE, EXEC, WB, TRAP.
- IDLE: when start=1, go to FETCH next cycle.
- FETCH: imem_req=1 and imem_addr=pc, held stable until ack. When imem_ack=1, latch instr<=imem_rdata and go to DECODE. imem_req deasserts the cycle after ack. Wait states are unbounded.
- DECODE: opcode is instr[6:0], funct3 is instr[14:12], funct7 is instr[31:25].
  - R-type (0110011), decoded on {funct7,funct3}:
    - 0000000_000 gives ADD.
    - 0100000_000 gives SUB.
    - 0000000_110 gives OR.
    - 0000000_111 gives AND.
    - R-type sets bsel=0.
  - I-type (0010011), decoded on funct3 only:
    - 000 gives ADD.
    - 110 gives OR.
    - 111 gives AND.
    - I-type sets bsel=1.
  - Any other opcode or combination goes to TRAP. alu_op and bsel are registered here and hold through EXEC and WB.
- EXEC: one cycle for the ALU result to settle. No outputs change.
- WB: reg_wen=1 for exactly one cycle, unless rd (instr[11:7]) is 0, in which case reg_wen=0. retired=1. pc<=pc+PC_STEP (modulo 2^32; 32'hFFFF_FFFC wraps to 0). Next state is IDLE if stop=1, else FETCH.
- TRAP: illegal=1, busy=0, no fetch, pc frozen at the offending instruction's address. Only reset exits TRAP; start and stop are ignored.
- Minimum latency with zero-wait ack is 4 cycles per instruction (FETCH, DECODE, EXEC, WB), with retired once per 4 cycles.
- start and stop high together in IDLE: start wins and fetch begins. stop then takes effect at the next WB.
- stop asserted outside WB has no effect until it is sampled in WB.
- alu_op and bsel are never left unassigned; every decoded path drives both, so no latches are inferred.

Optional Feature:
Macro MULTICYCLE_CORE_CTRL_PERF_EN.
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0].
  - cycle_cnt increments every cycle while busy=1.
  - instret_cnt increments on every retired pulse.
  - Both wrap at 2^32 and clear on reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Reset check: hold rst_n=0 for 2 cycles, with start high during reset. Required: pc=0, reg_wen=0, imem_req=0, illegal=0. FETCH begins on the first cycle after release, since start is level-sensitive.
2. Zero-wait ADD: start=1 with ack in the same cycle as req and rdata=32'h002081B3 (add x3,x1,x2). Required: alu_op=0010, bsel=0, and reg_wen pulses in the 4th cycle. pc goes 0 to 4. The next fetch is at 4.
3. Wait-state ADDI: ack delayed 3 cycles, rdata=32'h00508093 (addi x1,x1,5). Required: imem_addr is stable for all 4 request cycles, alu_op=0010, bsel=1, and retire occurs 7 cycles after fetch start.
4. Mixed stream of SUB (32'h40208033), OR (x6 funct3), then AND with rd=0. Required: alu_op sequence 0110, 0001, 0000. The AND has reg_wen=0 but retired=1.
5. Illegal instruction: rdata=32'h00000073. Required: TRAP after DECODE, illegal=1, busy=0, no further imem_req, pc frozen. Only rst_n=0 recovers.
6. Control corner cases:
   - stop=1 in WB of an instruction at pc=8: goes to IDLE with pc=12. A later start resumes fetch at 12.
   - rst_n=0 mid-FETCH: state returns to IDLE and pc=RESET_PC.
   - With PERF_EN defined: instret_cnt=2 after two retires, and cycle_cnt=8 with zero waits.
